// File: rtl/alert_frame_tx_if.sv
// Byte-stream handshake from the alert framer into the UART transmitter.
// The master drives data/valid; the slave answers with ready.
interface alert_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/alert_frame_tx.sv
// Queues qualifying detection events and serialises each one into a
// 6-byte SYNC/SEQ/CLASS/FLAGS/DROPS/CHK record for the UART.
module alert_frame_tx #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter bit         ALERT_ONLY = 1'b1
) (
  input  logic                        clk_125mhz,
  input  logic                        rst_n,
  input  logic                        det_valid,
  input  logic                        anomaly_flag,
  input  logic [7:0]                  class_label,
  alert_frame_tx_if.master            tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_n;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    head;
  logic [2:0]    idx;
  logic [7:0]    seq, drop_cnt;
  logic [7:0]    f_seq, f_class;
  logic [7:0]    f_flags, f_drops;
  logic [7:0]    cur_byte;
  logic          empty, full;
  logic          qualify, push_req;
  logic          push, drop;
  logic          pop, last;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign qualify  = !ALERT_ONLY || anomaly_flag ||
                    (class_label != 8'd0);
  assign push_req = det_valid && qualify;
  // Full is judged before any same-cycle pop.
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;
  assign busy       = (state != IDLE);

  always_comb begin
    cur_byte = 8'd0;
    case (idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = f_seq;
      3'd2:    cur_byte = f_class;
      3'd3:    cur_byte = f_flags;
      3'd4:    cur_byte = f_drops;
      3'd5:    cur_byte = f_seq ^ f_class ^
                          f_flags ^ f_drops;
      default: cur_byte = 8'd0;
    endcase
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    last        = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'd0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = cur_byte;
        last        = tx.tx_ready && (idx == 3'd5);
        if (last) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_125mhz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {anomaly_flag, class_label};
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= 8'd0;
      drop_cnt <= 8'd0;
      f_seq    <= 8'd0;
      f_class  <= 8'd0;
      f_flags  <= 8'd0;
      f_drops  <= 8'd0;
    end else if (pop) begin
      f_seq    <= seq;
      f_class  <= head[7:0];
      f_drops  <= drop_cnt;
      f_flags  <= {5'd0, drop_cnt != 8'd0,
                   head[7:0] != 8'd0, head[8]};
      seq      <= seq + 8'd1;
      // A drop on the latch cycle belongs to the next frame.
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 3'd0;
    end else if (pop) begin
      idx <= 3'd0;
    end else if (tx.tx_valid && tx.tx_ready) begin
      idx <= last ? 3'd0 : idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_alert_frame_tx.sv
// Randomised and directed scoreboard bench for alert_frame_tx against a
// queue-based event/frame model.
module tb_alert_frame_tx;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk_125mhz = 1'b0;
  logic          rst_n = 1'b0;
  logic          det_valid = 1'b0;
  logic          anomaly_flag = 1'b0;
  logic [7:0]    class_label = 8'd0;
  logic [LW-1:0] fifo_level;
  logic          busy;

  alert_frame_tx_if tx ();

  alert_frame_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_125mhz  (clk_125mhz),
    .rst_n       (rst_n),
    .det_valid   (det_valid),
    .anomaly_flag(anomaly_flag),
    .class_label (class_label),
    .tx          (tx),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #4 clk_125mhz = ~clk_125mhz;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference model: event queue, frame-in-flight byte count,
  // sequence and drop counters, expected byte stream.
  logic [8:0] mq[$];
  logic [7:0] expq[$];
  int         rem = 0;
  logic [7:0] mseq = 8'd0;
  logic [7:0] mdrops = 8'd0;

  always @(posedge clk_125mhz or negedge rst_n) begin
    bit qual, mfull, mpop, mdrop;
    logic [8:0] e;
    logic [7:0] cl, fl;
    if (!rst_n) begin
      mq.delete();
      expq.delete();
      rem = 0;
      mseq = 8'd0;
      mdrops = 8'd0;
    end else begin
      qual  = det_valid &&
              (anomaly_flag || class_label != 8'd0);
      mfull = (mq.size() == DEPTH);
      mpop  = (rem == 0) && (mq.size() > 0);
      mdrop = qual && mfull;
      if (rem > 0 && tx.tx_ready) rem--;
      if (mpop) begin
        e  = mq.pop_front();
        cl = e[7:0];
        fl = {5'd0, mdrops != 8'd0, cl != 8'd0, e[8]};
        expq.push_back(8'hA5);
        expq.push_back(mseq);
        expq.push_back(cl);
        expq.push_back(fl);
        expq.push_back(mdrops);
        expq.push_back(mseq ^ cl ^ fl ^ mdrops);
        rem = 6;
        mseq = mseq + 8'd1;
        mdrops = mdrop ? 8'd1 : 8'd0;
      end else if (mdrop && mdrops != 8'hFF) begin
        mdrops = mdrops + 8'd1;
      end
      if (qual && !mfull)
        mq.push_back({anomaly_flag, class_label});
    end
  end

  // Monitor: compares the DUT stream with the model on the falling edge.
  logic [47:0] frames[$];
  logic [47:0] cur = '0;
  int          pos = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;

  always @(negedge clk_125mhz) begin
    logic [7:0] eb;
    if (!rst_n) begin
      pos = 0;
      prev_stall = 1'b0;
    end else begin
      chk("tx_valid", tx.tx_valid, rem > 0);
      chk("busy", busy, rem > 0);
      chk("fifo_level", fifo_level, mq.size());
      if (prev_stall) begin
        chk("hold_valid", tx.tx_valid, 1'b1);
        chk("hold_data", tx.tx_data, prev_data);
      end
      if (tx.tx_valid && tx.tx_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_byte", 1'b1, 1'b0);
        end else begin
          eb = expq.pop_front();
          chk("byte", tx.tx_data, eb);
        end
        cur = {cur[39:0], tx.tx_data};
        pos++;
        if (pos == 6) begin
          frames.push_back(cur);
          pos = 0;
        end
      end
      prev_stall = tx.tx_valid && !tx.tx_ready;
      prev_data  = tx.tx_data;
    end
  end

  function automatic logic [7:0] fb(input logic [47:0] f,
                                    input int k);
    return f[8*(5-k) +: 8];
  endfunction

  task automatic step();
    @(posedge clk_125mhz);
    #1;
  endtask

  task automatic ev(input logic a, input logic [7:0] c);
    det_valid = 1'b1;
    anomaly_flag = a;
    class_label = c;
    step();
    det_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    tx.tx_ready = 1'b1;
    while ((expq.size() > 0 || rem > 0 || mq.size() > 0)
           && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", n < budget, 1'b1);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tx_valid", tx.tx_valid, 1'b0);
    chk("rst_tx_data", tx.tx_data, 8'd0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int b, w, peak;
    logic [47:0] f;
    tx.tx_ready = 1'b0;
    #1;
    do_reset();

    // 1: single alert, ready high
    b = frames.size();
    tx.tx_ready = 1'b1;
    ev(1'b1, 8'd5);
    drain(50);
    chk("t1_count", frames.size() - b, 1);
    if (frames.size() > b)
      chk("t1_frame", frames[b], 48'hA5_00_05_03_00_06);

    // 2: stall on the first byte
    b = frames.size();
    tx.tx_ready = 1'b0;
    ev(1'b1, 8'd5);
    w = 0;
    while (!tx.tx_valid && w < 10) begin
      step();
      w++;
    end
    chk("t2_valid_rise", tx.tx_valid, 1'b1);
    repeat (10) begin
      chk("t2_stall_data", tx.tx_data, 8'hA5);
      step();
    end
    drain(50);
    if (frames.size() > b)
      chk("t2_frame", frames[b], 48'hA5_01_05_03_00_07);
    else
      chk("t2_count", frames.size() - b, 1);

    // 3: benign event is filtered
    ev(1'b0, 8'd0);
    repeat (5) begin
      chk("t3_level", fifo_level, 0);
      chk("t3_valid", tx.tx_valid, 1'b0);
      step();
    end

    // 4: burst of 10 into a stalled link
    do_reset();
    b = frames.size();
    tx.tx_ready = 1'b0;
    peak = 0;
    for (int i = 0; i < 10; i++) begin
      ev(1'b0, 8'(i + 1));
      if (fifo_level > peak) peak = fifo_level;
    end
    repeat (3) begin
      step();
      if (fifo_level > peak) peak = fifo_level;
    end
    chk("t4_peak", peak, 8);
    drain(200);
    chk("t4_count", frames.size() - b, 9);
    if (frames.size() >= b + 2) begin
      chk("t4_f1_drops", fb(frames[b], 4), 8'd0);
      chk("t4_f2_drops", fb(frames[b+1], 4), 8'd1);
      chk("t4_f2_flag2", fb(frames[b+1], 3) & 8'h04, 8'h04);
    end

    // 5: sequence wrap
    do_reset();
    b = frames.size();
    for (int i = 0; i < 257; i++) begin
      ev(1'($urandom), 8'($urandom_range(1, 255)));
      drain(30);
    end
    chk("t5_count", frames.size() - b, 257);
    if (frames.size() >= b + 257) begin
      chk("t5_seq255", fb(frames[b+255], 1), 8'hFF);
      f = frames[b+256];
      chk("t5_seq256", fb(f, 1), 8'h00);
      chk("t5_chk256", fb(f, 5),
          fb(f, 1) ^ fb(f, 2) ^ fb(f, 3) ^ fb(f, 4));
    end

    // 6: reset mid-frame with queued events
    do_reset();
    tx.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) ev(1'b1, 8'(i + 7));
    chk("t6_level_before", fifo_level, 4);
    tx.tx_ready = 1'b1;
    repeat (3) step();
    tx.tx_ready = 1'b0;
    do_reset();
    b = frames.size();
    ev(1'b0, 8'd9);
    drain(50);
    if (frames.size() > b)
      chk("t6_seq", fb(frames[b], 1), 8'h00);
    else
      chk("t6_count", frames.size() - b, 1);

    // random traffic with random back-pressure
    repeat (400) begin
      det_valid    = ($urandom % 3) == 0;
      anomaly_flag = ($urandom % 4) == 0;
      class_label  = (($urandom % 3) == 0) ?
                     8'($urandom) : 8'd0;
      tx.tx_ready  = 1'($urandom);
      step();
    end
    det_valid = 1'b0;
    drain(2000);
    chk("final_expq_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
